// File: rtl/menlo_cnc_pkg.sv
// menlo_cnc_pkg: shared types and constants for the step/dir axis blocks
package menlo_cnc_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} step_dec_state_t;
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;
endpackage

// File: rtl/edge_synchronizer.sv
// edge_synchronizer: multi-flop synchronizer with registered rise/fall detection
module edge_synchronizer #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [sync_stages-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[sync_stages-2:0], d};
    prev_d = sync_q[sync_stages-1];
  end
  // Deliberately unreset: a level held across reset must not appear as a fresh edge.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end
  assign level = sync_q[sync_stages-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: step/dir receiver; define STEP_DIR_CHECK_EN for direction setup/hold checking
module step_dir_decoder
  import menlo_cnc_pkg::*;
#(
  parameter int width       = 32,
  parameter int sync_stages = 2,
  parameter int min_width   = 2,
  parameter int dir_setup   = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic [width-1:0] timeout,
  output logic [width-1:0] position,
  output logic [width-1:0] step_count,
  output logic [width-1:0] last_period,
  output logic [width-1:0] last_width,
  output logic             period_valid,
  output logic             width_valid,
  output logic             moving,
  output logic             glitch_error,
  output logic             dir_error
);
  logic step_lvl, step_rise, step_fall;
  logic dir_lvl, dir_rise, dir_fall;
  step_dec_state_t state_q, state_d;
  logic [width-1:0] pos_q, pos_d, cnt_q, cnt_d, per_q, per_d, wid_q, wid_d;
  logic [width-1:0] pc_q, pc_d, wc_q, wc_d;
  logic pv_q, pv_d, wv_q, wv_d, mov_q, mov_d, gerr_q, gerr_d;

  edge_synchronizer #(.sync_stages(sync_stages)) u_step (
    .clk(clock_in), .d(step_in), .level(step_lvl), .rise(step_rise), .fall(step_fall)
  );
  edge_synchronizer #(.sync_stages(sync_stages)) u_dir (
    .clk(clock_in), .d(dir_in), .level(dir_lvl), .rise(dir_rise), .fall(dir_fall)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    wid_d   = wid_q;
    pv_d    = 1'b0;
    wv_d    = 1'b0;
    mov_d   = mov_q;
    gerr_d  = gerr_q;
    pc_d    = (&pc_q) ? pc_q : pc_q + 1'b1;
    wc_d    = (state_q == HIGH && !(&wc_q)) ? wc_q + 1'b1 : wc_q;
    if (clear) begin
      state_d = IDLE;
      pos_d   = '0;
      cnt_d   = '0;
      gerr_d  = 1'b0;
      mov_d   = 1'b0;
    end else if (!enable) begin
      state_d = IDLE;
      pc_d    = pc_q;
      wc_d    = wc_q;
    end else if (step_rise && state_q != HIGH) begin
      pos_d   = pos_q + ((dir_lvl == DIR_CW) ? width'(1) : {width{1'b1}});
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      mov_d   = 1'b1;
      state_d = HIGH;
      pc_d    = width'(1);
      wc_d    = width'(1);
      per_d   = (state_q == LOW) ? pc_q : per_q;
      pv_d    = (state_q == LOW);
    end else if (step_fall && state_q == HIGH) begin
      wid_d   = wc_q;
      wv_d    = 1'b1;
      state_d = LOW;
      gerr_d  = gerr_q | (wc_q < width'(min_width));
    end else if (state_q == LOW && timeout != '0 && pc_q >= timeout) begin
      state_d = IDLE;
      mov_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      wid_q   <= '0;
      pc_q    <= '0;
      wc_q    <= '0;
      pv_q    <= 1'b0;
      wv_q    <= 1'b0;
      mov_q   <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      pc_q    <= pc_d;
      wc_q    <= wc_d;
      pv_q    <= pv_d;
      wv_q    <= wv_d;
      mov_q   <= mov_d;
      gerr_q  <= gerr_d;
    end
  end

`ifdef STEP_DIR_CHECK_EN
  localparam int dw = $clog2(dir_setup + 2);
  logic [dw-1:0] dc_q, dc_d;
  logic derr_q, derr_d, dir_chg;
  // dc_q counts clocks since the last dir change, so a rising step with dc_q < dir_setup lacked setup
  always_comb begin
    dir_chg = dir_rise | dir_fall;
    dc_d    = dir_chg ? dw'(1) : (dc_q >= dw'(dir_setup)) ? dc_q : dc_q + 1'b1;
    derr_d  = derr_q;
    if (clear)
      derr_d = 1'b0;
    else if (enable && ((dir_chg && state_q == HIGH) ||
             (step_rise && state_q != HIGH && (dir_chg || dc_q < dw'(dir_setup)))))
      derr_d = 1'b1;
  end
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      dc_q   <= dw'(dir_setup);
      derr_q <= 1'b0;
    end else begin
      dc_q   <= dc_d;
      derr_q <= derr_d;
    end
  end
  assign dir_error = derr_q;
`else
  localparam int unused_dir_setup = dir_setup;
  logic unused_dir_chg;
  assign unused_dir_chg = dir_rise | dir_fall;
  assign dir_error = 1'b0;
`endif

  assign position     = pos_q;
  assign step_count   = cnt_q;
  assign last_period  = per_q;
  assign last_width   = wid_q;
  assign period_valid = pv_q;
  assign width_valid  = wv_q;
  assign moving       = mov_q;
  assign glitch_error = gerr_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed self-checking bench for step_dir_decoder
module tb_step_dir_decoder;
  logic clk = 1'b0;
  logic reset_n, enable, clear, step_in, dir_in;
  logic [31:0] timeout, position, step_count, last_period, last_width;
  logic period_valid, width_valid, moving, glitch_error, dir_error;
  int total = 0, bad = 0;
  int pv_cnt = 0, wv_cnt = 0, cyc = 0, rise_cyc = 0, fall_cyc = 0;
  int pv_mark, wv_mark;
  logic [31:0] sc_prev = '0;
  logic mov_prev = 1'b0;
  logic derr_exp;

  step_dir_decoder dut (
    .clock_in(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .step_in(step_in), .dir_in(dir_in), .timeout(timeout),
    .position(position), .step_count(step_count), .last_period(last_period),
    .last_width(last_width), .period_valid(period_valid), .width_valid(width_valid),
    .moving(moving), .glitch_error(glitch_error), .dir_error(dir_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (period_valid) pv_cnt = pv_cnt + 1;
    if (width_valid) wv_cnt = wv_cnt + 1;
    if (step_count != sc_prev) rise_cyc = cyc;
    if (mov_prev && !moving) fall_cyc = cyc;
    sc_prev  = step_count;
    mov_prev = moving;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef STEP_DIR_CHECK_EN
    derr_exp = 1'b1;
`else
    derr_exp = 1'b0;
`endif
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; step_in = 1'b0; dir_in = 1'b0; timeout = '0;
    tick(5);
    check("rst_position", position, 0);
    check("rst_count", step_count, 0);
    check("rst_period", last_period, 0);
    check("rst_width", last_width, 0);
    check("rst_flags", {27'd0, period_valid, width_valid, moving, glitch_error, dir_error}, 0);
    reset_n = 1'b1;
    tick(3);

    for (int i = 0; i < 4; i++) pulse(3, 7);
    tick(5);
    check("g1_position", position, 4);
    check("g1_count", step_count, 4);
    check("g1_period", last_period, 10);
    check("g1_width", last_width, 3);
    check("g1_pv_strobes", pv_cnt, 3);
    check("g1_wv_strobes", wv_cnt, 4);

    dir_in = 1'b1;
    tick(5);
    for (int i = 0; i < 16; i++) pulse(2, 2);
    tick(5);
    check("g2_position", position, 32'hFFFF_FFF4);
    check("g2_count", step_count, 20);
    check("g2_period", last_period, 4);
    check("g2_width", last_width, 2);
    check("g2_errors", {glitch_error, dir_error}, 0);

    dir_in = 1'b0;
    tick(5);
    pulse(1, 6);
    check("glitch_set", glitch_error, 1);
    check("glitch_position", position, 32'hFFFF_FFF5);
    check("glitch_width", last_width, 1);
    pulse(3, 6);
    check("glitch_held", glitch_error, 1);
    check("glitch_position2", position, 32'hFFFF_FFF6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    check("clr_position", position, 0);
    check("clr_count", step_count, 0);
    check("clr_glitch", glitch_error, 0);
    check("clr_keep_period", last_period, 7);
    check("clr_keep_width", last_width, 3);

    timeout = 32'd50;
    pulse(3, 7);
    pulse(3, 7);
    check("to_moving_high", moving, 1);
    tick(60);
    check("to_moving_low", moving, 0);
    check("to_delay", fall_cyc - rise_cyc, 50);
    pv_mark = pv_cnt;
    pulse(3, 7);
    tick(3);
    check("to_no_period", pv_cnt - pv_mark, 0);
    check("to_count", step_count, 3);
    check("to_moving_again", moving, 1);
    timeout = '0;

    tick(5);
    step_in = 1'b1;
    tick(2);
    dir_in = 1'b1;
    tick(1);
    step_in = 1'b0;
    tick(6);
    check("dir_hold", dir_error, {31'd0, derr_exp});
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("dir_clr", dir_error, 0);
    dir_in = 1'b0;
    tick(2);
    pulse(3, 6);
    check("dir_setup_ok", dir_error, 0);
    tick(5);
    dir_in = 1'b1;
    tick(1);
    pulse(3, 6);
    check("dir_setup_bad", dir_error, {31'd0, derr_exp});

    tick(5);
    wv_mark = wv_cnt;
    step_in = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    step_in = 1'b0;
    tick(6);
    check("rstmid_no_width", wv_cnt - wv_mark, 0);
    check("rstmid_count0", step_count, 0);
    pv_mark = pv_cnt;
    pulse(3, 7);
    tick(3);
    check("rstmid_count1", step_count, 1);
    check("rstmid_no_period", pv_cnt - pv_mark, 0);
    check("rstmid_width", wv_cnt - wv_mark, 1);
    check("rstmid_position", position, 32'hFFFF_FFFF);
    check("rstmid_dir_error", dir_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
